// File: rtl/key_nav_pkg.sv
// Shared keycode constants, direction/edit encodings and typematic states
// for the tracker-grid keyboard navigation controller.
package key_nav_pkg;

    localparam logic [7:0] KEY_W = 8'h1A;
    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_I = 8'h0C;
    localparam logic [7:0] KEY_K = 8'h0E;
    localparam logic [7:0] KEY_P = 8'h13;
    localparam logic [7:0] KEY_H = 8'h0B;

    typedef enum logic [2:0] {
        DIR_NONE = 3'b000,
        DIR_L    = 3'b001,
        DIR_R    = 3'b010,
        DIR_U    = 3'b011,
        DIR_D    = 3'b100
    } dir_e;

    typedef enum logic [1:0] {
        EDIT_NONE = 2'b00,
        EDIT_INC  = 2'b01,
        EDIT_DEC  = 2'b10,
        EDIT_DEL  = 2'b11
    } edit_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_DELAY  = 2'b01,
        ST_REPEAT = 2'b10
    } rep_state_e;

    function automatic dir_e decode_dir(input logic [7:0] code);
        dir_e d;
        d = DIR_NONE;
        case (code)
            KEY_W:   d = DIR_U;
            KEY_A:   d = DIR_L;
            KEY_S:   d = DIR_D;
            KEY_D:   d = DIR_R;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    function automatic edit_e decode_edit(input logic [7:0] code);
        edit_e e;
        e = EDIT_NONE;
        case (code)
            KEY_I:   e = EDIT_INC;
            KEY_K:   e = EDIT_DEC;
            KEY_P:   e = EDIT_DEL;
            default: e = EDIT_NONE;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/key_nav_repeat.sv
// Typematic auto-repeat engine: turns a held direction into a step pulse
// on press, after REPEAT_DELAY cycles, then every REPEAT_RATE cycles.
module key_nav_repeat
    import key_nav_pkg::*;
#(
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic       clk,
    input  logic       Reset_n,
    input  logic [2:0] active_dir,
    input  logic       home,
    output logic       step,
    output logic [2:0] step_dir
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(REPEAT_RATE - 1);

    rep_state_e       state, state_next;
    dir_e             held_dir, held_next;
    dir_e             dir_in;
    logic [CNT_W-1:0] cnt, cnt_next;

    assign dir_in = dir_e'(active_dir);

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state    <= ST_IDLE;
            held_dir <= DIR_NONE;
            cnt      <= '0;
        end else begin
            state    <= state_next;
            held_dir <= held_next;
            cnt      <= cnt_next;
        end
    end

    // Home parks the engine in IDLE so releasing it acts like a fresh press.
    always_comb begin
        state_next = state;
        held_next  = held_dir;
        cnt_next   = cnt;
        step       = 1'b0;
        step_dir   = DIR_NONE;
        if (home) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (dir_in != DIR_NONE) begin
                        step       = 1'b1;
                        step_dir   = dir_in;
                        held_next  = dir_in;
                        cnt_next   = DELAY_LOAD;
                        state_next = ST_DELAY;
                    end
                end
                ST_DELAY, ST_REPEAT: begin
                    if (dir_in == DIR_NONE) begin
                        state_next = ST_IDLE;
                    end else if (dir_in != held_dir) begin
                        step       = 1'b1;
                        step_dir   = dir_in;
                        held_next  = dir_in;
                        cnt_next   = DELAY_LOAD;
                        state_next = ST_DELAY;
                    end else if (cnt == '0) begin
                        step       = 1'b1;
                        step_dir   = held_dir;
                        cnt_next   = RATE_LOAD;
                        state_next = ST_REPEAT;
                    end else begin
                        cnt_next = cnt - CNT_W'(1);
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/key_nav_ctrl.sv
// Keyboard navigation controller: decodes HID keycode slots into a wrapping
// grid cursor, one-shot edit commands and a home command.
module key_nav_ctrl
    import key_nav_pkg::*;
#(
    parameter int GRID_W       = 80,
    parameter int GRID_H       = 30,
    parameter int NUM_KEYS     = 2,
    parameter int REPEAT_DELAY = 25_000_000,
    parameter int REPEAT_RATE  = 5_000_000
) (
    input  logic                      clk,
    input  logic                      Reset_n,
    input  logic [8*NUM_KEYS-1:0]     keycode,
    output logic [$clog2(GRID_W)-1:0] cursor_x,
    output logic [$clog2(GRID_H)-1:0] cursor_y,
    output logic                      move_valid,
    output logic [2:0]                move_dir,
    output logic                      edit_valid,
    output logic [1:0]                edit_cmd
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);
    localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);

    dir_e          active_dir;
    edit_e         active_edit;
    edit_e         prev_edit;
    logic          home_present;
    logic          home_prev;
    logic          home_rise;
    logic          edit_fire;
    logic          step;
    logic [2:0]    step_dir;
    logic [7:0]    slot;
    logic [XW-1:0] x_next;
    logic [YW-1:0] y_next;

    // Scan from the top slot down so the lowest-index match wins.
    always_comb begin
        active_dir   = DIR_NONE;
        active_edit  = EDIT_NONE;
        home_present = 1'b0;
        slot         = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            slot = keycode[8*i +: 8];
            if (decode_dir(slot) != DIR_NONE)
                active_dir = decode_dir(slot);
            if (decode_edit(slot) != EDIT_NONE)
                active_edit = decode_edit(slot);
            if (slot == KEY_H)
                home_present = 1'b1;
        end
    end

    assign home_rise = home_present && !home_prev;
    assign edit_fire = (active_edit != EDIT_NONE) && (active_edit != prev_edit);

    key_nav_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
    ) u_repeat (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .active_dir (active_dir),
        .home       (home_present),
        .step       (step),
        .step_dir   (step_dir)
    );

    always_comb begin
        x_next = cursor_x;
        y_next = cursor_y;
        if (home_rise) begin
            x_next = '0;
            y_next = '0;
        end else if (step) begin
            case (dir_e'(step_dir))
                DIR_L:   x_next = (cursor_x == '0)     ? X_LAST : cursor_x - XW'(1);
                DIR_R:   x_next = (cursor_x == X_LAST) ? '0     : cursor_x + XW'(1);
                DIR_U:   y_next = (cursor_y == '0)     ? Y_LAST : cursor_y - YW'(1);
                DIR_D:   y_next = (cursor_y == Y_LAST) ? '0     : cursor_y + YW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cursor_x   <= '0;
            cursor_y   <= '0;
            move_valid <= 1'b0;
            move_dir   <= DIR_NONE;
            edit_valid <= 1'b0;
            edit_cmd   <= EDIT_NONE;
            prev_edit  <= EDIT_NONE;
            home_prev  <= 1'b0;
        end else begin
            cursor_x   <= x_next;
            cursor_y   <= y_next;
            move_valid <= step;
            move_dir   <= step ? step_dir : DIR_NONE;
            edit_valid <= edit_fire;
            edit_cmd   <= edit_fire ? active_edit : EDIT_NONE;
            prev_edit  <= active_edit;
            home_prev  <= home_present;
        end
    end

endmodule

// File: tb/tb_key_nav_ctrl.sv
// Directed, table-driven bench for key_nav_ctrl with short repeat timings
// plus hand sequences for edit hold, home and reset during repeat.
module tb_key_nav_ctrl;

    logic        clk;
    logic        Reset_n;
    logic [15:0] keycode;
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        move_valid;
    logic [2:0]  move_dir;
    logic        edit_valid;
    logic [1:0]  edit_cmd;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] kc;
        logic        mv;
        logic [2:0]  dir;
        logic [6:0]  x;
        logic [4:0]  y;
        logic        ev;
        logic [1:0]  cmd;
    } vec_t;

    vec_t vecs[$];

    key_nav_ctrl #(
        .GRID_W       (80),
        .GRID_H       (30),
        .NUM_KEYS     (2),
        .REPEAT_DELAY (4),
        .REPEAT_RATE  (2)
    ) dut (
        .clk        (clk),
        .Reset_n    (Reset_n),
        .keycode    (keycode),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y),
        .move_valid (move_valid),
        .move_dir   (move_dir),
        .edit_valid (edit_valid),
        .edit_cmd   (edit_cmd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic [15:0] kc, input logic mv, input logic [2:0] dir,
                          input int x, input int y, input logic ev, input logic [1:0] cmd);
        vec_t v;
        v.kc = kc; v.mv = mv; v.dir = dir; v.x = 7'(x); v.y = 5'(y); v.ev = ev; v.cmd = cmd;
        vecs.push_back(v);
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [15:0] kc);
        @(negedge clk);
        keycode = kc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input logic mv, input logic [2:0] dir,
                               input int x, input int y, input logic ev, input logic [1:0] cmd);
        checkValue({tag, " move_valid"}, int'(move_valid), int'(mv));
        checkValue({tag, " move_dir"},   int'(move_dir),   int'(dir));
        checkValue({tag, " cursor_x"},   int'(cursor_x),   x);
        checkValue({tag, " cursor_y"},   int'(cursor_y),   y);
        checkValue({tag, " edit_valid"}, int'(edit_valid), int'(ev));
        checkValue({tag, " edit_cmd"},   int'(edit_cmd),   int'(cmd));
    endtask

    task automatic tap(input logic [15:0] kc);
        applyStimulus(kc);
        applyStimulus(16'h0000);
    endtask

    initial begin
        int pulses;
        int last_cmd;

        // Single tap right, then a single left back to column 0.
        addVec(16'h0007, 1, 3'b010,  1,  0, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000,  1,  0, 0, 2'b00);
        addVec(16'h0004, 1, 3'b001,  0,  0, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000,  0,  0, 0, 2'b00);
        // Hold left for 10 cycles: steps at t0, t0+4, t0+6, t0+8 with wrap.
        addVec(16'h0004, 1, 3'b001, 79,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 79,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 79,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 79,  0, 0, 2'b00);
        addVec(16'h0004, 1, 3'b001, 78,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 78,  0, 0, 2'b00);
        addVec(16'h0004, 1, 3'b001, 77,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 77,  0, 0, 2'b00);
        addVec(16'h0004, 1, 3'b001, 76,  0, 0, 2'b00);
        addVec(16'h0004, 0, 3'b000, 76,  0, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 76,  0, 0, 2'b00);
        // Two up taps wrap row 0 to 29, then 28.
        addVec(16'h001A, 1, 3'b011, 76, 29, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 76, 29, 0, 2'b00);
        addVec(16'h001A, 1, 3'b011, 76, 28, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 76, 28, 0, 2'b00);
        // Hold down from row 28: 29, then wrap to 0 on the first repeat.
        addVec(16'h0016, 1, 3'b100, 76, 29, 0, 2'b00);
        addVec(16'h0016, 0, 3'b000, 76, 29, 0, 2'b00);
        addVec(16'h0016, 0, 3'b000, 76, 29, 0, 2'b00);
        addVec(16'h0016, 0, 3'b000, 76, 29, 0, 2'b00);
        addVec(16'h0016, 1, 3'b100, 76,  0, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 76,  0, 0, 2'b00);
        // Up in slot0 beats right in slot1; clearing slot0 restarts the delay.
        addVec(16'h071A, 1, 3'b011, 76, 29, 0, 2'b00);
        addVec(16'h071A, 0, 3'b000, 76, 29, 0, 2'b00);
        addVec(16'h0700, 1, 3'b010, 77, 29, 0, 2'b00);
        addVec(16'h0700, 0, 3'b000, 77, 29, 0, 2'b00);
        addVec(16'h0700, 0, 3'b000, 77, 29, 0, 2'b00);
        addVec(16'h0700, 0, 3'b000, 77, 29, 0, 2'b00);
        addVec(16'h0700, 1, 3'b010, 78, 29, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 78, 29, 0, 2'b00);
        // Edit commands: one pulse per new command, no auto-repeat.
        addVec(16'h000C, 0, 3'b000, 78, 29, 1, 2'b01);
        addVec(16'h000C, 0, 3'b000, 78, 29, 0, 2'b00);
        addVec(16'h000C, 0, 3'b000, 78, 29, 0, 2'b00);
        addVec(16'h0C0E, 0, 3'b000, 78, 29, 1, 2'b10);
        addVec(16'h0C0E, 0, 3'b000, 78, 29, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 78, 29, 0, 2'b00);
        addVec(16'h0013, 0, 3'b000, 78, 29, 1, 2'b11);
        addVec(16'h0013, 0, 3'b000, 78, 29, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000, 78, 29, 0, 2'b00);
        // Move and edit in the same cycle, then right wraps 79 to 0.
        addVec(16'h0C07, 1, 3'b010, 79, 29, 1, 2'b01);
        addVec(16'h0000, 0, 3'b000, 79, 29, 0, 2'b00);
        addVec(16'h0007, 1, 3'b010,  0, 29, 0, 2'b00);
        addVec(16'h0000, 0, 3'b000,  0, 29, 0, 2'b00);

        Reset_n = 1'b0;
        keycode = 16'h0000;
        #17;
        checkOutput("reset", 0, 3'b000, 0, 0, 0, 2'b00);
        @(negedge clk);
        Reset_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].kc);
            checkOutput($sformatf("v%0d", i), vecs[i].mv, vecs[i].dir,
                        int'(vecs[i].x), int'(vecs[i].y), vecs[i].ev, vecs[i].cmd);
        end

        // Holding dec for 20 cycles yields exactly one pulse.
        pulses   = 0;
        last_cmd = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'h000E);
            if (edit_valid) begin
                pulses++;
                last_cmd = int'(edit_cmd);
            end
        end
        checkValue("hold dec pulses", pulses, 1);
        checkValue("hold dec cmd", last_cmd, 2);
        applyStimulus(16'h0000);

        // Walk to (5,7) then press home.
        for (int i = 0; i < 5; i++) tap(16'h0007);
        for (int i = 0; i < 8; i++) tap(16'h0016);
        checkOutput("at 5,7", 0, 3'b000, 5, 7, 0, 2'b00);
        applyStimulus(16'h000B);
        checkOutput("home", 0, 3'b000, 0, 0, 0, 2'b00);
        applyStimulus(16'h070B);
        checkOutput("home+R", 0, 3'b000, 0, 0, 0, 2'b00);
        applyStimulus(16'h070B);
        checkOutput("home+R held", 0, 3'b000, 0, 0, 0, 2'b00);
        applyStimulus(16'h0000);
        checkOutput("home release", 0, 3'b000, 0, 0, 0, 2'b00);

        // Hold right into REPEAT, then reset asynchronously.
        applyStimulus(16'h0007);
        checkOutput("pre-reset step", 1, 3'b010, 1, 0, 0, 2'b00);
        for (int i = 0; i < 3; i++) applyStimulus(16'h0007);
        applyStimulus(16'h0007);
        checkOutput("pre-reset repeat", 1, 3'b010, 2, 0, 0, 2'b00);
        #2;
        Reset_n = 1'b0;
        #1;
        checkOutput("async reset", 0, 3'b000, 0, 0, 0, 2'b00);
        @(negedge clk);
        Reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post-reset press", 1, 3'b010, 1, 0, 0, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
